pipelined_instruction_decoder: RTL and testbench

Registered RV32I decode stage sitting between fetch and execute. It accepts one instruction plus PC per cycle through a valid/ready handshake. It produces the same control bundle as the current combinational decoder, one cycle later, with a 2-entry skid buffer for back-pressure. New relative to the current decoder:
- optional M-extension decode;
- AUIPC, FENCE, ECALL and EBREAK decode;
- strict opcode and funct7 legality checks;
- rd=x0 write suppression;
- pipeline flush.

---
 rtl/pipelined_instruction_decoder_pkg.sv | 98 +++++++++
 rtl/pipelined_instruction_decoder_if.sv | 57 +++++
 rtl/pipelined_instruction_decoder_decode_core.sv | 183 ++++++++++++++++++
 rtl/pipelined_instruction_decoder.sv | 99 +++++++++
 tb/tb_pipelined_instruction_decoder.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_instruction_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared encodings and the control-bundle type for the
//                registered RV32I(M) decode stage.
//  Revision    : 1.0  initial release
// ============================================================================
package decoder_pkg;

    // Major opcodes (full 7-bit match, bits[1:0] included)
    localparam logic [6:0] C_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] C_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] C_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] C_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] C_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] C_OPC_OP       = 7'b0110011;
    localparam logic [6:0] C_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] C_OPC_SYSTEM   = 7'b1110011;

    // ALU operand source selects
    localparam logic [2:0] C_LHS_RS1    = 3'd0;
    localparam logic [2:0] C_LHS_IMM    = 3'd1;
    localparam logic [2:0] C_LHS_PC     = 3'd4;
    localparam logic [1:0] C_RHS_RS2    = 2'd0;
    localparam logic [1:0] C_RHS_IMM    = 2'd1;
    localparam logic [1:0] C_RHS_CONST4 = 2'd3;

    // ALU op codes: bit4 = MulDiv, bits3:0 = {alt, funct3}
    localparam logic [4:0] C_ALU_ADD = 5'b00000;
    localparam logic [4:0] C_ALU_AND = 5'b00111;
    localparam logic [4:0] C_ALU_MUL = 5'b10000;

    // Branch conditions
    localparam logic [2:0] C_BR_EQ  = 3'd0;
    localparam logic [2:0] C_BR_NE  = 3'd1;
    localparam logic [2:0] C_BR_LTU = 3'd2;
    localparam logic [2:0] C_BR_LT  = 3'd3;
    localparam logic [2:0] C_BR_GEU = 3'd4;
    localparam logic [2:0] C_BR_GE  = 3'd5;

    // Memory access widths
    localparam logic [1:0] C_MEM_BYTE = 2'd0;
    localparam logic [1:0] C_MEM_HALF = 2'd1;
    localparam logic [1:0] C_MEM_WORD = 2'd2;

    // System operations
    localparam logic [1:0] C_SYS_FENCE  = 2'd0;
    localparam logic [1:0] C_SYS_ECALL  = 2'd1;
    localparam logic [1:0] C_SYS_EBREAK = 2'd2;

    localparam logic [31:0] C_WORD_ECALL  = 32'h0000_0073;
    localparam logic [31:0] C_WORD_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  lhs_src;
        logic [1:0]  rhs_src;
        logic [4:0]  alu_op;
        logic        writes_rf;
        logic        is_branch;
        logic        is_jump;
        logic        jump_mode;
        logic [2:0]  branch_cond;
        logic        mem_read;
        logic        mem_write;
        logic        mem_sign_ext;
        logic [1:0]  mem_width;
        logic        is_system;
        logic [1:0]  system_op;
        logic        invalid;
    } decode_t;

    typedef struct packed {
        logic [31:0] pc;
        decode_t     dec;
    } stage_t;

    // Maps branch funct3 to {legal, condition code}
    function automatic logic [3:0] branch_cond_of(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return {1'b1, C_BR_EQ};
            3'b001:  return {1'b1, C_BR_NE};
            3'b100:  return {1'b1, C_BR_LT};
            3'b101:  return {1'b1, C_BR_GE};
            3'b110:  return {1'b1, C_BR_LTU};
            3'b111:  return {1'b1, C_BR_GEU};
            default: return {1'b0, C_BR_EQ};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_instruction_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_instruction_decoder_if
//  Description : Fetch-side and execute-side handshake plus decoded bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipelined_instruction_decoder_if;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instruction;
    logic [31:0] InPC;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutPC;
    logic [4:0]  RD;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic [31:0] DecodedImediate;
    logic [2:0]  LHSsource;
    logic [1:0]  RHSsource;
    logic [4:0]  ALUOperation;
    logic        WritesRegisterFile;
    logic        IsBranchInstruction;
    logic        IsJumpInstruction;
    logic        JumpMode;
    logic [2:0]  BranchCondition;
    logic        IsMemoryRead;
    logic        IsMemoryWrite;
    logic        MemoryAccessSignExtend;
    logic [1:0]  MemoryAccessWidth;
    logic        IsSystem;
    logic [1:0]  SystemOp;
    logic        InvalidInstructionSignal;

    // Decoder side
    modport slave (
        input  InValid, Instruction, InPC, OutReady,
        output InReady, OutValid, OutPC, RD, RS1, RS2, DecodedImediate,
               LHSsource, RHSsource, ALUOperation, WritesRegisterFile,
               IsBranchInstruction, IsJumpInstruction, JumpMode,
               BranchCondition, IsMemoryRead, IsMemoryWrite,
               MemoryAccessSignExtend, MemoryAccessWidth, IsSystem,
               SystemOp, InvalidInstructionSignal
    );

    // Environment side (fetch + execute)
    modport master (
        output InValid, Instruction, InPC, OutReady,
        input  InReady, OutValid, OutPC, RD, RS1, RS2, DecodedImediate,
               LHSsource, RHSsource, ALUOperation, WritesRegisterFile,
               IsBranchInstruction, IsJumpInstruction, JumpMode,
               BranchCondition, IsMemoryRead, IsMemoryWrite,
               MemoryAccessSignExtend, MemoryAccessWidth, IsSystem,
               SystemOp, InvalidInstructionSignal
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_instruction_decoder_decode_core.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_decode_core
//  Description : Purely combinational RV32I(+M, +FENCE/ECALL/EBREAK) decoder
//                producing the control bundle and an illegal flag.
//  Revision    : 1.0  initial release
// ============================================================================
module rv32_decode_core
    import decoder_pkg::*;
#(
    parameter bit ENABLE_M          = 1'b1,
    parameter bit ENABLE_SYSTEM     = 1'b1,
    parameter bit SUPPRESS_X0_WRITE = 1'b1
) (
    input  logic [31:0] instruction,
    output decode_t     bundle
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [3:0]  w_br;
    logic        w_legal;
    decode_t     w_dec;

    assign w_opcode = instruction[6:0];
    assign w_funct3 = instruction[14:12];
    assign w_funct7 = instruction[31:25];
    assign w_imm_i  = {{20{instruction[31]}}, instruction[31:20]};
    assign w_imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign w_imm_b  = {{19{instruction[31]}}, instruction[31], instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
    assign w_imm_u  = {instruction[31:12], 12'b0};
    assign w_imm_j  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                       instruction[20], instruction[30:21], 1'b0};
    assign w_br     = branch_cond_of(w_funct3);

    // Field decode, then legality masking of side-effect flags
    always_comb begin
        w_dec     = '0;
        w_legal   = 1'b0;
        w_dec.rd  = instruction[11:7];
        w_dec.rs1 = instruction[19:15];
        w_dec.rs2 = instruction[24:20];

        case (w_opcode)
            C_OPC_LUI: begin
                // Both operands are the immediate so AND passes it through
                w_legal         = 1'b1;
                w_dec.imm       = w_imm_u;
                w_dec.lhs_src   = C_LHS_IMM;
                w_dec.rhs_src   = C_RHS_IMM;
                w_dec.alu_op    = C_ALU_AND;
                w_dec.writes_rf = 1'b1;
            end
            C_OPC_AUIPC: begin
                w_legal         = 1'b1;
                w_dec.imm       = w_imm_u;
                w_dec.lhs_src   = C_LHS_PC;
                w_dec.rhs_src   = C_RHS_IMM;
                w_dec.alu_op    = C_ALU_ADD;
                w_dec.writes_rf = 1'b1;
            end
            C_OPC_JAL: begin
                // ALU computes the link value PC+4; target uses the immediate
                w_legal         = 1'b1;
                w_dec.imm       = w_imm_j;
                w_dec.is_jump   = 1'b1;
                w_dec.jump_mode = 1'b0;
                w_dec.lhs_src   = C_LHS_PC;
                w_dec.rhs_src   = C_RHS_CONST4;
                w_dec.alu_op    = C_ALU_ADD;
                w_dec.writes_rf = 1'b1;
            end
            C_OPC_JALR: begin
                w_legal         = (w_funct3 == 3'b000);
                w_dec.imm       = w_imm_i;
                w_dec.is_jump   = 1'b1;
                w_dec.jump_mode = 1'b1;
                w_dec.lhs_src   = C_LHS_PC;
                w_dec.rhs_src   = C_RHS_CONST4;
                w_dec.alu_op    = C_ALU_ADD;
                w_dec.writes_rf = 1'b1;
            end
            C_OPC_BRANCH: begin
                w_legal           = w_br[3];
                w_dec.imm         = w_imm_b;
                w_dec.is_branch   = 1'b1;
                w_dec.branch_cond = w_br[2:0];
            end
            C_OPC_LOAD: begin
                // LB/LH/LW/LBU/LHU only
                w_legal            = (w_funct3[1:0] != 2'b11) && (w_funct3 != 3'b110);
                w_dec.imm          = w_imm_i;
                w_dec.mem_read     = 1'b1;
                w_dec.mem_width    = w_funct3[1:0];
                w_dec.mem_sign_ext = ~w_funct3[2];
                w_dec.rhs_src      = C_RHS_IMM;
                w_dec.alu_op       = C_ALU_ADD;
                w_dec.writes_rf    = 1'b1;
            end
            C_OPC_STORE: begin
                w_legal         = !w_funct3[2] && (w_funct3[1:0] != 2'b11);
                w_dec.imm       = w_imm_s;
                w_dec.mem_write = 1'b1;
                w_dec.mem_width = w_funct3[1:0];
                w_dec.rhs_src   = C_RHS_IMM;
                w_dec.alu_op    = C_ALU_ADD;
            end
            C_OPC_OP_IMM: begin
                // Bit 30 only selects SRA on shifts; elsewhere it is immediate
                w_legal         = 1'b1;
                w_dec.imm       = w_imm_i;
                w_dec.rhs_src   = C_RHS_IMM;
                w_dec.alu_op    = {2'b00, w_funct3};
                w_dec.writes_rf = 1'b1;
                if (w_funct3 == 3'b001) begin
                    w_legal = (w_funct7 == 7'b0000000);
                end else if (w_funct3 == 3'b101) begin
                    w_legal      = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                    w_dec.alu_op = {1'b0, instruction[30], w_funct3};
                end
            end
            C_OPC_OP: begin
                w_dec.writes_rf = 1'b1;
                case (w_funct7)
                    7'b0000000: begin
                        w_legal      = 1'b1;
                        w_dec.alu_op = {2'b00, w_funct3};
                    end
                    7'b0100000: begin
                        w_legal      = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
                        w_dec.alu_op = {2'b01, w_funct3};
                    end
                    7'b0000001: begin
                        w_legal      = ENABLE_M;
                        w_dec.alu_op = {2'b10, w_funct3};
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            C_OPC_MISC_MEM: begin
                w_legal         = ENABLE_SYSTEM && (w_funct3 == 3'b000);
                w_dec.is_system = 1'b1;
                w_dec.system_op = C_SYS_FENCE;
            end
            C_OPC_SYSTEM: begin
                w_dec.is_system = 1'b1;
                if (instruction == C_WORD_ECALL) begin
                    w_legal         = ENABLE_SYSTEM;
                    w_dec.system_op = C_SYS_ECALL;
                end else if (instruction == C_WORD_EBREAK) begin
                    w_legal         = ENABLE_SYSTEM;
                    w_dec.system_op = C_SYS_EBREAK;
                end
            end
            default: w_legal = 1'b0;
        endcase

        if (!w_legal) begin
            w_dec.invalid   = 1'b1;
            w_dec.writes_rf = 1'b0;
            w_dec.mem_read  = 1'b0;
            w_dec.mem_write = 1'b0;
            w_dec.is_branch = 1'b0;
            w_dec.is_jump   = 1'b0;
            w_dec.is_system = 1'b0;
        end

        if (SUPPRESS_X0_WRITE && (w_dec.rd == 5'd0)) begin
            w_dec.writes_rf = 1'b0;
        end
    end

    assign bundle = w_dec;

endmodule
`default_nettype wire

// File: rtl/pipelined_instruction_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_instruction_decoder
//  Description : Registered decode stage: valid/ready handshake, output
//                register plus one skid entry, flush.
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_instruction_decoder
    import decoder_pkg::*;
#(
    parameter bit ENABLE_M          = 1'b1,
    parameter bit ENABLE_SYSTEM     = 1'b1,
    parameter bit SUPPRESS_X0_WRITE = 1'b1
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic                            Flush,
    pipelined_instruction_decoder_if.slave  bus
);

    decode_t w_dec;
    stage_t  w_incoming;
    logic    w_in_xfer;
    logic    w_out_xfer;

    logic    r_out_valid;
    stage_t  r_out;
    logic    r_skid_valid;
    stage_t  r_skid;

    rv32_decode_core #(
        .ENABLE_M          (ENABLE_M),
        .ENABLE_SYSTEM     (ENABLE_SYSTEM),
        .SUPPRESS_X0_WRITE (SUPPRESS_X0_WRITE)
    ) u_core (
        .instruction (bus.Instruction),
        .bundle      (w_dec)
    );

    assign w_incoming.pc  = bus.InPC;
    assign w_incoming.dec = w_dec;

    // Ready depends only on the skid register (and reset), never on OutReady
    assign bus.InReady = ~r_skid_valid & ~Reset;
    assign w_in_xfer   = bus.InValid & bus.InReady;
    assign w_out_xfer  = r_out_valid & bus.OutReady;

    // Output register and skid entry; flush drops occupancy but keeps payload
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (Flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || w_out_xfer) begin
            // Output slot frees up: refill from skid first to keep FIFO order
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_out        <= w_incoming;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid       <= w_incoming;
            r_skid_valid <= 1'b1;
        end
    end

    assign bus.OutValid                 = r_out_valid;
    assign bus.OutPC                    = r_out.pc;
    assign bus.RD                       = r_out.dec.rd;
    assign bus.RS1                      = r_out.dec.rs1;
    assign bus.RS2                      = r_out.dec.rs2;
    assign bus.DecodedImediate          = r_out.dec.imm;
    assign bus.LHSsource                = r_out.dec.lhs_src;
    assign bus.RHSsource                = r_out.dec.rhs_src;
    assign bus.ALUOperation             = r_out.dec.alu_op;
    assign bus.WritesRegisterFile       = r_out.dec.writes_rf;
    assign bus.IsBranchInstruction      = r_out.dec.is_branch;
    assign bus.IsJumpInstruction        = r_out.dec.is_jump;
    assign bus.JumpMode                 = r_out.dec.jump_mode;
    assign bus.BranchCondition          = r_out.dec.branch_cond;
    assign bus.IsMemoryRead             = r_out.dec.mem_read;
    assign bus.IsMemoryWrite            = r_out.dec.mem_write;
    assign bus.MemoryAccessSignExtend   = r_out.dec.mem_sign_ext;
    assign bus.MemoryAccessWidth        = r_out.dec.mem_width;
    assign bus.IsSystem                 = r_out.dec.is_system;
    assign bus.SystemOp                 = r_out.dec.system_op;
    assign bus.InvalidInstructionSignal = r_out.dec.invalid;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_instruction_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_instruction_decoder
//  Description : Directed self-checking bench for the registered decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_instruction_decoder;

    logic Clock = 1'b0;
    logic Reset;
    logic Flush;
    int   checks   = 0;
    int   failures = 0;

    always #5 Clock = ~Clock;

    pipelined_instruction_decoder_if bus ();
    pipelined_instruction_decoder_if bus_nm ();

    pipelined_instruction_decoder #(
        .ENABLE_M (1'b1), .ENABLE_SYSTEM (1'b1), .SUPPRESS_X0_WRITE (1'b1)
    ) u_dut (
        .Clock (Clock), .Reset (Reset), .Flush (Flush), .bus (bus)
    );

    pipelined_instruction_decoder #(
        .ENABLE_M (1'b0), .ENABLE_SYSTEM (1'b1), .SUPPRESS_X0_WRITE (1'b1)
    ) u_dut_nom (
        .Clock (Clock), .Reset (Reset), .Flush (Flush), .bus (bus_nm)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Presents one instruction for exactly one cycle
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        bus.InValid     = 1'b1;
        bus.Instruction = instr;
        bus.InPC        = pc;
        tick();
        bus.InValid     = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Flush = 1'b0;
        bus.InValid = 1'b0; bus.OutReady = 1'b1; bus.Instruction = '0; bus.InPC = '0;
        bus_nm.InValid = 1'b0; bus_nm.OutReady = 1'b1; bus_nm.Instruction = '0; bus_nm.InPC = '0;
        tick();
        tick();
        checks++;
        if ({bus.OutValid, bus.InReady} !== 2'b00) begin
            failures++;
            $display("FAIL reset_valid_ready: got %b required 00", {bus.OutValid, bus.InReady});
        end
        checks++;
        if ({bus.OutPC, bus.DecodedImediate, bus.RD, bus.WritesRegisterFile} !== 70'd0) begin
            failures++;
            $display("FAIL reset_payload: got pc=%h imm=%h rd=%0d wr=%b required zeros",
                     bus.OutPC, bus.DecodedImediate, bus.RD, bus.WritesRegisterFile);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if ({bus.OutValid, bus.InReady} !== 2'b01) begin
            failures++;
            $display("FAIL post_reset_ready: got %b required 01", {bus.OutValid, bus.InReady});
        end
    endtask

    task automatic test_addi_auipc_load();
        send(32'h0050_0093, 32'h0000_0100);   // ADDI x1,x0,5
        checks++;
        if ({bus.OutValid, bus.RD, bus.DecodedImediate, bus.RHSsource, bus.ALUOperation,
             bus.WritesRegisterFile, bus.InvalidInstructionSignal}
            !== {1'b1, 5'd1, 32'd5, 2'd1, 5'b00000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL addi_fields: got v=%b rd=%0d imm=%h rhs=%0d alu=%b wr=%b inv=%b required v=1 rd=1 imm=5 rhs=1 alu=00000 wr=1 inv=0",
                     bus.OutValid, bus.RD, bus.DecodedImediate, bus.RHSsource, bus.ALUOperation,
                     bus.WritesRegisterFile, bus.InvalidInstructionSignal);
        end
        checks++;
        if ({bus.OutPC, bus.LHSsource} !== {32'h0000_0100, 3'd0}) begin
            failures++;
            $display("FAIL addi_pc_lhs: got pc=%h lhs=%0d required pc=100 lhs=0", bus.OutPC, bus.LHSsource);
        end
        send(32'h0000_1117, 32'h0000_0200);   // AUIPC x2,1
        checks++;
        if ({bus.LHSsource, bus.RHSsource, bus.ALUOperation, bus.WritesRegisterFile,
             bus.DecodedImediate, bus.RD} !== {3'd4, 2'd1, 5'b00000, 1'b1, 32'h0000_1000, 5'd2}) begin
            failures++;
            $display("FAIL auipc_fields: got lhs=%0d rhs=%0d alu=%b wr=%b imm=%h rd=%0d required lhs=4 rhs=1 alu=00000 wr=1 imm=1000 rd=2",
                     bus.LHSsource, bus.RHSsource, bus.ALUOperation, bus.WritesRegisterFile,
                     bus.DecodedImediate, bus.RD);
        end
        send(32'h0080_A283, 32'h0000_0204);   // LW x5,8(x1)
        checks++;
        if ({bus.IsMemoryRead, bus.IsMemoryWrite, bus.MemoryAccessWidth, bus.MemoryAccessSignExtend,
             bus.WritesRegisterFile, bus.DecodedImediate} !== {1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 32'd8}) begin
            failures++;
            $display("FAIL lw_fields: got rd=%b wr=%b w=%0d se=%b rf=%b imm=%h required 1 0 2 1 1 8",
                     bus.IsMemoryRead, bus.IsMemoryWrite, bus.MemoryAccessWidth,
                     bus.MemoryAccessSignExtend, bus.WritesRegisterFile, bus.DecodedImediate);
        end
        tick();
    endtask

    task automatic test_mul();
        bus.InValid = 1'b1; bus.Instruction = 32'h0220_81B3; bus.InPC = 32'h300;
        bus_nm.InValid = 1'b1; bus_nm.Instruction = 32'h0220_81B3; bus_nm.InPC = 32'h300;
        tick();
        bus.InValid = 1'b0; bus_nm.InValid = 1'b0;
        checks++;
        if ({bus.ALUOperation, bus.InvalidInstructionSignal, bus.WritesRegisterFile}
            !== {5'b10000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mul_enabled: got alu=%b inv=%b wr=%b required alu=10000 inv=0 wr=1",
                     bus.ALUOperation, bus.InvalidInstructionSignal, bus.WritesRegisterFile);
        end
        checks++;
        if ({bus_nm.OutValid, bus_nm.InvalidInstructionSignal, bus_nm.WritesRegisterFile} !== 3'b110) begin
            failures++;
            $display("FAIL mul_disabled: got v=%b inv=%b wr=%b required v=1 inv=1 wr=0",
                     bus_nm.OutValid, bus_nm.InvalidInstructionSignal, bus_nm.WritesRegisterFile);
        end
        tick();
    endtask

    task automatic test_branch_shift();
        send(32'hFE20_CEE3, 32'h400);   // BLT x1,x2,-4
        checks++;
        if ({bus.IsBranchInstruction, bus.BranchCondition, bus.DecodedImediate,
             bus.WritesRegisterFile, bus.InvalidInstructionSignal}
            !== {1'b1, 3'd3, 32'hFFFF_FFFC, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL blt_fields: got br=%b cond=%0d imm=%h wr=%b inv=%b required br=1 cond=3 imm=fffffffc wr=0 inv=0",
                     bus.IsBranchInstruction, bus.BranchCondition, bus.DecodedImediate,
                     bus.WritesRegisterFile, bus.InvalidInstructionSignal);
        end
        send(32'h6030_D093, 32'h404);   // SRAI with bit29 set
        checks++;
        if ({bus.InvalidInstructionSignal, bus.WritesRegisterFile} !== 2'b10) begin
            failures++;
            $display("FAIL srai_bad_funct7: got inv=%b wr=%b required inv=1 wr=0",
                     bus.InvalidInstructionSignal, bus.WritesRegisterFile);
        end
        send(32'h4030_D093, 32'h408);   // SRAI x1,x1,3
        checks++;
        if ({bus.InvalidInstructionSignal, bus.ALUOperation, bus.WritesRegisterFile} !== {1'b0, 5'b01101, 1'b1}) begin
            failures++;
            $display("FAIL srai_ok: got inv=%b alu=%b wr=%b required inv=0 alu=01101 wr=1",
                     bus.InvalidInstructionSignal, bus.ALUOperation, bus.WritesRegisterFile);
        end
        tick();
    endtask

    task automatic test_x0_system();
        send(32'h0010_0013, 32'h500);   // ADDI x0,x0,1
        checks++;
        if ({bus.WritesRegisterFile, bus.InvalidInstructionSignal, bus.DecodedImediate} !== {2'b00, 32'd1}) begin
            failures++;
            $display("FAIL x0_suppress: got wr=%b inv=%b imm=%h required wr=0 inv=0 imm=1",
                     bus.WritesRegisterFile, bus.InvalidInstructionSignal, bus.DecodedImediate);
        end
        send(32'h0000_0073, 32'h504);   // ECALL
        checks++;
        if ({bus.IsSystem, bus.SystemOp, bus.WritesRegisterFile, bus.InvalidInstructionSignal} !== {1'b1, 2'd1, 2'b00}) begin
            failures++;
            $display("FAIL ecall: got sys=%b op=%0d wr=%b inv=%b required sys=1 op=1 wr=0 inv=0",
                     bus.IsSystem, bus.SystemOp, bus.WritesRegisterFile, bus.InvalidInstructionSignal);
        end
        send(32'h0010_0073, 32'h508);   // EBREAK
        checks++;
        if ({bus.IsSystem, bus.SystemOp, bus.InvalidInstructionSignal} !== {1'b1, 2'd2, 1'b0}) begin
            failures++;
            $display("FAIL ebreak: got sys=%b op=%0d inv=%b required sys=1 op=2 inv=0",
                     bus.IsSystem, bus.SystemOp, bus.InvalidInstructionSignal);
        end
        send(32'h3000_2073, 32'h50C);   // CSRRS: not supported
        checks++;
        if ({bus.InvalidInstructionSignal, bus.IsSystem, bus.WritesRegisterFile} !== 3'b100) begin
            failures++;
            $display("FAIL csr_illegal: got inv=%b sys=%b wr=%b required inv=1 sys=0 wr=0",
                     bus.InvalidInstructionSignal, bus.IsSystem, bus.WritesRegisterFile);
        end
        tick();
    endtask

    task automatic test_back_pressure();
        bus.OutReady = 1'b0;
        bus.InValid = 1'b1; bus.Instruction = 32'h0050_0093; bus.InPC = 32'h1000;
        tick();
        checks++;
        if ({bus.OutValid, bus.InReady, bus.OutPC} !== {2'b11, 32'h1000}) begin
            failures++;
            $display("FAIL bp_first: got v=%b rdy=%b pc=%h required v=1 rdy=1 pc=1000",
                     bus.OutValid, bus.InReady, bus.OutPC);
        end
        bus.Instruction = 32'h0050_0113; bus.InPC = 32'h1004;
        tick();
        checks++;
        if ({bus.OutValid, bus.InReady, bus.OutPC, bus.RD} !== {2'b10, 32'h1000, 5'd1}) begin
            failures++;
            $display("FAIL bp_skid_full: got v=%b rdy=%b pc=%h rd=%0d required v=1 rdy=0 pc=1000 rd=1",
                     bus.OutValid, bus.InReady, bus.OutPC, bus.RD);
        end
        bus.Instruction = 32'h0050_0193; bus.InPC = 32'h1008;
        tick();
        checks++;
        if ({bus.InReady, bus.OutPC} !== {1'b0, 32'h1000}) begin
            failures++;
            $display("FAIL bp_stall: got rdy=%b pc=%h required rdy=0 pc=1000", bus.InReady, bus.OutPC);
        end
        bus.OutReady = 1'b1;
        tick();
        checks++;
        if ({bus.OutValid, bus.InReady, bus.OutPC, bus.RD} !== {2'b11, 32'h1004, 5'd2}) begin
            failures++;
            $display("FAIL bp_drain_skid: got v=%b rdy=%b pc=%h rd=%0d required v=1 rdy=1 pc=1004 rd=2",
                     bus.OutValid, bus.InReady, bus.OutPC, bus.RD);
        end
        tick();
        bus.InValid = 1'b0;
        checks++;
        if ({bus.OutValid, bus.OutPC, bus.RD} !== {1'b1, 32'h1008, 5'd3}) begin
            failures++;
            $display("FAIL bp_third: got v=%b pc=%h rd=%0d required v=1 pc=1008 rd=3",
                     bus.OutValid, bus.OutPC, bus.RD);
        end
        tick();
        checks++;
        if (bus.OutValid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: got v=%b required 0", bus.OutValid);
        end
    endtask

    task automatic test_flush();
        bus.OutReady = 1'b0;
        send(32'h0050_0093, 32'h2000);
        send(32'h0050_0113, 32'h2004);
        bus.InValid = 1'b1; bus.Instruction = 32'h0050_0193; bus.InPC = 32'h2008;
        Flush = 1'b1;
        tick();
        Flush = 1'b0; bus.InValid = 1'b0;
        checks++;
        if ({bus.OutValid, bus.InReady} !== 2'b01) begin
            failures++;
            $display("FAIL flush_full: got v=%b rdy=%b required v=0 rdy=1", bus.OutValid, bus.InReady);
        end
        bus.OutReady = 1'b1;
        send(32'h0050_0093, 32'h3000);
        bus.InValid = 1'b1; bus.Instruction = 32'h0050_0113; bus.InPC = 32'h3004;
        Flush = 1'b1;
        tick();
        Flush = 1'b0; bus.InValid = 1'b0;
        checks++;
        if (bus.OutValid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop_incoming: got v=%b pc=%h required v=0", bus.OutValid, bus.OutPC);
        end
        tick();
        checks++;
        if (bus.OutValid !== 1'b0) begin
            failures++;
            $display("FAIL flush_stays_empty: got v=%b pc=%h required v=0", bus.OutValid, bus.OutPC);
        end
        send(32'h0050_0193, 32'h3008);
        checks++;
        if ({bus.OutValid, bus.OutPC} !== {1'b1, 32'h3008}) begin
            failures++;
            $display("FAIL flush_recover: got v=%b pc=%h required v=1 pc=3008", bus.OutValid, bus.OutPC);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        bus.OutReady = 1'b0;
        send(32'h0050_0093, 32'h4000);
        bus.InValid = 1'b1; bus.Instruction = 32'h0050_0113; bus.InPC = 32'h4004;
        Reset = 1'b1;
        tick();
        checks++;
        if ({bus.OutValid, bus.InReady, bus.OutPC} !== {2'b00, 32'h0}) begin
            failures++;
            $display("FAIL reset_mid: got v=%b rdy=%b pc=%h required v=0 rdy=0 pc=0",
                     bus.OutValid, bus.InReady, bus.OutPC);
        end
        Reset = 1'b0; bus.InValid = 1'b0;
        tick();
        checks++;
        if ({bus.OutValid, bus.InReady} !== 2'b01) begin
            failures++;
            $display("FAIL reset_mid_after: got v=%b rdy=%b required v=0 rdy=1", bus.OutValid, bus.InReady);
        end
        bus.OutReady = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi_auipc_load();
        test_mul();
        test_branch_shift();
        test_x0_system();
        test_back_pressure();
        test_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
